tx_tlp_gen: RTL and testbench

Parametrised PCIe memory-write traffic generator for the 256-bit application-side Avalon-ST TX path. It arbitrates for the TX bus via req/gnt and issues a programmed burst of 4DW-header MWr TLPs with runtime-selectable payload length, address stepping and data pattern. It honours TX backpressure. It sits beside the other TX sources under the PCIe application arbiter and serves as a bring-up and throughput-test master.

---
 rtl/pcie_app_pkg.sv | 88 ++++++++
 rtl/tx_tlp_payld_gen.sv | 47 ++++
 rtl/tx_tlp_gen.sv | 192 +++++++++++++++++++
 tb/tb_tx_tlp_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_app_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_app_pkg
// Purpose  : Shared types and constants for the PCIe application-side TX path:
//            Avalon-ST sideband, TLP header DW layouts, fmt/type and empty
//            encodings, the latched traffic-generator configuration, and a
//            helper that checks a generator configuration for legality.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pcie_app_pkg;

   // TLP fmt field
   localparam logic [2:0] FMT_3DW_NO_DATA = 3'b000;
   localparam logic [2:0] FMT_4DW_NO_DATA = 3'b001;
   localparam logic [2:0] FMT_3DW_W_DATA  = 3'b010;
   localparam logic [2:0] FMT_4DW_W_DATA  = 3'b011;

   // TLP type field (memory requests share type 0, fmt decides rd/wr)
   localparam logic [4:0] TYPE_MRD = 5'b00000;
   localparam logic [4:0] TYPE_MWR = 5'b00000;

   // Avalon-ST empty encoding for a 256-bit beat (counted in 64-bit words)
   localparam logic [1:0] AVALON_255_0_VALID = 2'd0;
   localparam logic [1:0] AVALON_127_0_VALID = 2'd2;

   // Marker placed in the upper half of a sequence-stamped payload DW0
   localparam logic [15:0] SEQ_STAMP_TAG = 16'h5EC0;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic        valid;
      logic [1:0]  empty;
      logic        err;
      logic [31:0] parity;
   } tx_st_avalon_type;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [4:0]  typ;
      logic        t9;
      logic [2:0]  tc;
      logic        t8;
      logic        attr2;
      logic        ln;
      logic        th;
      logic        td;
      logic        ep;
      logic [1:0]  attr;
      logic [1:0]  at;
      logic [9:0]  length;
   } hdr0_type;

   typedef struct packed {
      logic [15:0] req_id;
      logic [7:0]  tag;
      logic [3:0]  lbe;
      logic [3:0]  fbe;
   } hdr1_type;

   typedef struct packed {
      logic [31:0] addr_hi;
      logic [29:0] addr_lo;
      logic [1:0]  rsvd;
   } hdr2_3_type;

   typedef struct packed {
      logic [10:0] payld_dw;
      logic        pat_mode;
      logic [31:0] pattern;
      logic [15:0] req_id;
   } tlp_gen_cfg_t;

   // Payload must be a power of two within [4, max_dw] and the base address
   // aligned to the TLP byte span, so no TLP of the burst crosses 4KB.
   function automatic logic tlp_cfg_ok(input logic [10:0] n,
                                       input logic [11:0] base_lo,
                                       input int          max_dw);
      logic [12:0] span_mask;
      span_mask = {n, 2'b00} - 13'd1;
      return (n >= 11'd4) && (int'(n) <= max_dw) &&
             ((n & (n - 11'd1)) == 11'd0) &&
             (({1'b0, base_lo} & span_mask) == 13'd0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tx_tlp_payld_gen.sv
`default_nettype none
// ============================================================================
// Module   : tx_tlp_payld_gen
// Purpose  : Produces the eight payload DWs of one 256-bit TX beat.
//            Optional sequence stamp controlled by TX_TLP_GEN_SEQ_STAMP_EN.
// Ports    : mode  - 0 fixed seed, 1 seed + global DW index
//            seed  - fixed word / increment seed
//            g     - global index of the first payload DW in this beat
//            first - beat 0 of a TLP (payload only in lanes 4..7)
//            seq   - TLP sequence number (stamp build only)
//            data  - 256-bit payload, lowest DW in [31:0]
// Revision : 1.0  initial release
// ============================================================================
module tx_tlp_payld_gen
   import pcie_app_pkg::*;
(
   input  logic         mode,
   input  logic [31:0]  seed,
   input  logic [31:0]  g,
   input  logic         first,
`ifdef TX_TLP_GEN_SEQ_STAMP_EN
   input  logic [15:0]  seq,
`endif
   output logic [255:0] data
);

   logic [255:0] lanes;

   // On the first beat payload starts in lane 4; lanes 0..3 compute indices
   // below g but are overlaid by the header in the parent.
   for (genvar i = 0; i < 8; i++) begin : g_lane
      logic [31:0] idx;
      assign idx = first ? (g + 32'(i) - 32'd4) : (g + 32'(i));
      assign lanes[i*32 +: 32] = mode ? (seed + idx) : seed;
   end

`ifdef TX_TLP_GEN_SEQ_STAMP_EN
   always_comb begin
      data = lanes;
      if (first) data[159:128] = {SEQ_STAMP_TAG, seq};
   end
`else
   assign data = lanes;
`endif

endmodule
`default_nettype wire

// File: rtl/tx_tlp_gen.sv
`default_nettype none
// ============================================================================
// Module   : tx_tlp_gen
// Purpose  : PCIe MWr traffic generator for the 256-bit Avalon-ST TX path.
//            Requests the bus, then issues a burst of 4DW-header MWr TLPs with
//            programmable length, address stepping and data pattern.
//            Optional build macro: TX_TLP_GEN_SEQ_STAMP_EN (stamp payload DW0).
// Ports    : iCLK/iRST            clock, async active-high reset
//            iSTART/iSTOP         launch pulse / end-of-burst request
//            iNUM_TLP..iPATTERN   burst configuration (latched at launch)
//            oREQ/iGNT            TX arbiter handshake
//            iTX_READY/oTX_ST/oTX_DATA  Avalon-ST TX beat interface
//            iCFG_BUSDEV/iFN_NUM  requester ID source
//            oBUSY/oDONE/oCFG_ERR status
// Revision : 1.0  initial release
// ============================================================================
module tx_tlp_gen
   import pcie_app_pkg::*;
#(
   parameter int MAX_PAYLD_DW = 128,
   parameter int CNT_W        = 16
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iSTART,
   input  logic             iSTOP,
   input  logic [CNT_W-1:0] iNUM_TLP,
   input  logic [10:0]      iPAYLD_DW,
   input  logic [63:0]      iBASE_ADDR,
   input  logic             iPAT_MODE,
   input  logic [31:0]      iPATTERN,
   output logic             oREQ,
   input  logic             iGNT,
   input  logic             iTX_READY,
   output tx_st_avalon_type oTX_ST,
   output logic [255:0]     oTX_DATA,
   input  logic [12:0]      iCFG_BUSDEV,
   input  logic [2:0]       iFN_NUM,
   output logic             oBUSY,
   output logic             oDONE,
   output logic             oCFG_ERR
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2, GAP = 2'd3} state_t;

   state_t           state;
   tlp_gen_cfg_t     cfg;
   logic [63:0]      addr;
   logic [CNT_W-1:0] remaining;
   logic             run_forever;
   logic [10:0]      beat;
   logic [31:0]      g_base;        // global DW index of this TLP's payload DW0
   logic             done_pulse;
   logic             cfg_err_pulse;
`ifdef TX_TLP_GEN_SEQ_STAMP_EN
   logic [15:0]      seq;
`endif

   logic [10:0]      last_beat;
   logic [31:0]      beat_g;
   logic [255:0]     payld;
   hdr0_type         hdr0;
   hdr1_type         hdr1;
   hdr2_3_type       hdr23;

   // B-1 = (4+N+7)/8 - 1 = (N+3)/8
   assign last_beat = (cfg.payld_dw + 11'd3) >> 3;

   // Beat 0 carries payload DW0..3, beat k>0 starts at payload DW 8k-4.
   assign beat_g = (beat == 11'd0) ? g_base
                                   : g_base + 32'({beat, 3'b000}) - 32'd4;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state         <= IDLE;
         cfg           <= '0;
         addr          <= '0;
         remaining     <= '0;
         run_forever   <= 1'b0;
         beat          <= '0;
         g_base        <= '0;
         done_pulse    <= 1'b0;
         cfg_err_pulse <= 1'b0;
`ifdef TX_TLP_GEN_SEQ_STAMP_EN
         seq           <= '0;
`endif
      end else begin
         done_pulse    <= 1'b0;
         cfg_err_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (iSTART) begin
                  cfg <= '{payld_dw: iPAYLD_DW, pat_mode: iPAT_MODE,
                           pattern: iPATTERN, req_id: {iCFG_BUSDEV, iFN_NUM}};
                  addr        <= iBASE_ADDR;
                  remaining   <= iNUM_TLP;
                  run_forever <= (iNUM_TLP == '0);
                  beat        <= '0;
                  g_base      <= '0;
`ifdef TX_TLP_GEN_SEQ_STAMP_EN
                  seq         <= '0;
`endif
                  if (tlp_cfg_ok(iPAYLD_DW, iBASE_ADDR[11:0], MAX_PAYLD_DW))
                     state <= REQ;
                  else
                     cfg_err_pulse <= 1'b1;
               end
            end
            REQ: begin
               if (iGNT) begin
                  state <= XFER;
                  beat  <= '0;
               end
            end
            XFER: begin
               // Grant is not re-checked here: a TLP always runs to eop.
               if (iTX_READY) begin
                  if (beat == last_beat) state <= GAP;
                  else                   beat  <= beat + 11'd1;
               end
            end
            GAP: begin
               if (!iGNT) begin
                  addr   <= addr + {51'd0, cfg.payld_dw, 2'b00};
                  g_base <= g_base + {21'd0, cfg.payld_dw};
                  if (!run_forever) remaining <= remaining - CNT_W'(1);
`ifdef TX_TLP_GEN_SEQ_STAMP_EN
                  seq    <= seq + 16'd1;
`endif
                  if ((!run_forever && (remaining == CNT_W'(1))) || iSTOP) begin
                     done_pulse <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     state <= REQ;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   tx_tlp_payld_gen u_payld (
      .mode  (cfg.pat_mode),
      .seed  (cfg.pattern),
      .g     (beat_g),
      .first (beat == 11'd0),
`ifdef TX_TLP_GEN_SEQ_STAMP_EN
      .seq   (seq),
`endif
      .data  (payld)
   );

   always_comb begin
      hdr0        = '0;
      hdr0.fmt    = FMT_4DW_W_DATA;
      hdr0.typ    = TYPE_MWR;
      hdr0.length = cfg.payld_dw[9:0];    // 1024 wraps to the 0 encoding
      hdr1        = '0;
      hdr1.req_id = cfg.req_id;
      hdr1.lbe    = 4'hF;
      hdr1.fbe    = 4'hF;
      hdr23       = '0;
      hdr23.addr_hi = addr[63:32];
      hdr23.addr_lo = addr[31:2];
   end

   always_comb begin
      oTX_ST       = '0;
      oTX_ST.empty = AVALON_255_0_VALID;
      oTX_DATA     = '0;
      if (state == XFER) begin
         oTX_ST.valid = 1'b1;
         oTX_ST.sop   = (beat == 11'd0);
         oTX_ST.eop   = (beat == last_beat);
         // N >= 8 (multiple of 8) leaves the last beat half full.
         if ((beat == last_beat) && (cfg.payld_dw[2:0] == 3'd0))
            oTX_ST.empty = AVALON_127_0_VALID;
         if (beat == 11'd0)
            oTX_DATA = {payld[255:128], hdr23[31:0], hdr23[63:32], hdr1, hdr0};
         else
            oTX_DATA = payld;
      end
   end

   assign oREQ     = (state == REQ) || (state == XFER);
   assign oBUSY    = (state != IDLE);
   assign oDONE    = done_pulse;
   assign oCFG_ERR = cfg_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_tx_tlp_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_tlp_gen
// Purpose  : Directed self-checking bench for tx_tlp_gen: single long TLP,
//            single-beat bursts, incrementing pattern with wrap, ready
//            backpressure, iSTOP on an endless burst, rejected configs and
//            reset mid-TLP.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_tx_tlp_gen;
   import pcie_app_pkg::*;

   localparam int CNT_W = 16;

   logic             iCLK = 1'b0;
   logic             iRST;
   logic             iSTART;
   logic             iSTOP;
   logic [CNT_W-1:0] iNUM_TLP;
   logic [10:0]      iPAYLD_DW;
   logic [63:0]      iBASE_ADDR;
   logic             iPAT_MODE;
   logic [31:0]      iPATTERN;
   logic             oREQ;
   logic             iGNT;
   logic             iTX_READY;
   tx_st_avalon_type oTX_ST;
   logic [255:0]     oTX_DATA;
   logic [12:0]      iCFG_BUSDEV;
   logic [2:0]       iFN_NUM;
   logic             oBUSY;
   logic             oDONE;
   logic             oCFG_ERR;

   int n_cmp = 0;
   int n_bad = 0;

   tx_tlp_gen #(.MAX_PAYLD_DW(128), .CNT_W(CNT_W)) dut (
      .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP),
      .iNUM_TLP(iNUM_TLP), .iPAYLD_DW(iPAYLD_DW), .iBASE_ADDR(iBASE_ADDR),
      .iPAT_MODE(iPAT_MODE), .iPATTERN(iPATTERN), .oREQ(oREQ), .iGNT(iGNT),
      .iTX_READY(iTX_READY), .oTX_ST(oTX_ST), .oTX_DATA(oTX_DATA),
      .iCFG_BUSDEV(iCFG_BUSDEV), .iFN_NUM(iFN_NUM), .oBUSY(oBUSY),
      .oDONE(oDONE), .oCFG_ERR(oCFG_ERR)
   );

   always #5 iCLK = ~iCLK;

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // Expected payload DW at TLP-local index p.
   function automatic logic [31:0] pdw(input logic mode, input logic [31:0] seed,
                                       input logic [31:0] g0, input int p);
      return mode ? (seed + g0 + 32'(p)) : seed;
   endfunction

   // Launch a burst, then scramble the config inputs to prove they were latched.
   task automatic start(input logic [10:0] n, input logic [63:0] base,
                        input logic [CNT_W-1:0] num, input logic mode, input logic [31:0] pat);
      iPAYLD_DW = n; iBASE_ADDR = base; iNUM_TLP = num; iPAT_MODE = mode; iPATTERN = pat;
      iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      iPAYLD_DW = 11'd0; iBASE_ADDR = '1; iNUM_TLP = '1; iPAT_MODE = ~mode;
      iPATTERN = 32'hDEAD_BEEF;
   endtask

   // Runs one TLP starting from the REQ state and ending one cycle after GAP.
   task automatic do_tlp(input logic [10:0] n, input logic [63:0] a, input logic mode,
                         input logic [31:0] seed, input logic [31:0] g0, input bit hold_gnt,
                         input bit toggle, input bit stop_mid, input string nm);
      int beats, acc, cyc, p;
      logic [255:0] exp, msk;
      beats = (int'(n) + 11) / 8;
      chk({nm, "_req"}, 256'(oREQ), 256'(1'b1));
      chk({nm, "_req_valid"}, 256'(oTX_ST.valid), 256'(1'b0));
      iGNT = 1'b1;
      tick();
      if (!hold_gnt) iGNT = 1'b0;
      acc = 0; cyc = 0; p = 0;
      while (acc < beats && cyc < 4 * beats + 8) begin
         iTX_READY = toggle ? ((cyc % 2) == 1) : 1'b1;
         if (stop_mid && acc == 1) iSTOP = 1'b1;
         exp = '0; msk = '0;
         if (acc == 0) begin
            exp[31:0]   = 32'h6000_0000 | {22'd0, n[9:0]};
            exp[63:32]  = 32'h121D_00FF;
            exp[95:64]  = a[63:32];
            exp[127:96] = {a[31:2], 2'b00};
            msk[127:0]  = '1;
            for (int j = 0; j < 4; j++) begin
               exp[128 + 32*j +: 32] = pdw(mode, seed, g0, j);
               msk[128 + 32*j +: 32] = '1;
            end
         end else begin
            for (int j = 0; j < 8; j++) begin
               if (p + j < int'(n)) begin
                  exp[32*j +: 32] = pdw(mode, seed, g0, p + j);
                  msk[32*j +: 32] = '1;
               end
            end
         end
         chk({nm, "_valid"}, 256'(oTX_ST.valid), 256'(1'b1));
         chk({nm, "_sop"}, 256'(oTX_ST.sop), 256'(acc == 0));
         chk({nm, "_eop"}, 256'(oTX_ST.eop), 256'(acc == beats - 1));
         if (acc == beats - 1)
            chk({nm, "_empty"}, 256'(oTX_ST.empty),
                256'((n[2:0] == 3'd0) ? 2'd2 : 2'd0));
         chk({nm, "_data"}, oTX_DATA & msk, exp);
         if (iTX_READY) begin
            p += (acc == 0) ? 4 : 8;
            acc++;
         end
         tick();
         cyc++;
      end
      iTX_READY = 1'b1;
      chk({nm, "_beats"}, 256'(acc), 256'(beats));
      chk({nm, "_gap_req"}, 256'(oREQ), 256'(1'b0));
      chk({nm, "_gap_valid"}, 256'(oTX_ST.valid), 256'(1'b0));
      chk({nm, "_gap_busy"}, 256'(oBUSY), 256'(1'b1));
      if (hold_gnt) begin
         tick();
         chk({nm, "_gap_hold_req"}, 256'(oREQ), 256'(1'b0));
         chk({nm, "_gap_hold_busy"}, 256'(oBUSY), 256'(1'b1));
         chk({nm, "_gap_hold_done"}, 256'(oDONE), 256'(1'b0));
      end
      iGNT = 1'b0;
      tick();
   endtask

   task automatic bad_start(input logic [10:0] n, input logic [63:0] base, input string nm);
      start(n, base, 16'd1, 1'b0, 32'h0);
      chk({nm, "_err"}, 256'(oCFG_ERR), 256'(1'b1));
      chk({nm, "_req"}, 256'(oREQ), 256'(1'b0));
      chk({nm, "_busy"}, 256'(oBUSY), 256'(1'b0));
      tick();
      chk({nm, "_err_pulse"}, 256'(oCFG_ERR), 256'(1'b0));
      chk({nm, "_req2"}, 256'(oREQ), 256'(1'b0));
   endtask

   task automatic chk_done(input string nm);
      chk({nm, "_done"}, 256'(oDONE), 256'(1'b1));
      chk({nm, "_idle_busy"}, 256'(oBUSY), 256'(1'b0));
      chk({nm, "_idle_req"}, 256'(oREQ), 256'(1'b0));
      tick();
      chk({nm, "_done_pulse"}, 256'(oDONE), 256'(1'b0));
   endtask

   initial begin
      iRST = 1'b1; iSTART = 1'b0; iSTOP = 1'b0; iNUM_TLP = '0; iPAYLD_DW = '0;
      iBASE_ADDR = '0; iPAT_MODE = 1'b0; iPATTERN = '0; iGNT = 1'b0; iTX_READY = 1'b1;
      iCFG_BUSDEV = 13'h243; iFN_NUM = 3'd5;        // req_id = 16'h121D
      tick();
      tick();
      chk("rst_req", 256'(oREQ), 256'(1'b0));
      chk("rst_busy", 256'(oBUSY), 256'(1'b0));
      chk("rst_st", 256'(oTX_ST), 256'(0));
      chk("rst_data", oTX_DATA, 256'(0));
      chk("rst_done", 256'(oDONE), 256'(1'b0));
      chk("rst_err", 256'(oCFG_ERR), 256'(1'b0));
      iRST = 1'b0;
      tick();

      // N=128, 17 beats, fixed pattern
      start(11'd128, 64'h0000_0001_2345_6000, 16'd1, 1'b0, 32'hAAAA_1111);
      chk("t1_err", 256'(oCFG_ERR), 256'(1'b0));
      chk("t1_busy", 256'(oBUSY), 256'(1'b1));
      do_tlp(11'd128, 64'h0000_0001_2345_6000, 1'b0, 32'hAAAA_1111, 32'd0, 1'b1, 1'b0, 1'b0, "t1");
      chk_done("t1");

      // N=4, three single-beat TLPs stepping by 16 bytes
      start(11'd4, 64'h2_0000_0000, 16'd3, 1'b0, 32'h1234_5678);
      do_tlp(11'd4, 64'h2_0000_0000, 1'b0, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0, "t2a");
      do_tlp(11'd4, 64'h2_0000_0010, 1'b0, 32'h1234_5678, 32'd4, 1'b1, 1'b0, 1'b0, "t2b");
      do_tlp(11'd4, 64'h2_0000_0020, 1'b0, 32'h1234_5678, 32'd8, 1'b1, 1'b0, 1'b0, "t2c");
      chk_done("t2");

      // N=8 incrementing from FFFFFFFE, address wraps through 2^64
      start(11'd8, 64'hFFFF_FFFF_FFFF_FFE0, 16'd2, 1'b1, 32'hFFFF_FFFE);
      do_tlp(11'd8, 64'hFFFF_FFFF_FFFF_FFE0, 1'b1, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, 1'b0, "t3a");
      do_tlp(11'd8, 64'h0, 1'b1, 32'hFFFF_FFFE, 32'd8, 1'b0, 1'b0, 1'b0, "t3b");
      chk_done("t3");

      // N=64 with ready toggling: 9 beats, each held across a stall
      start(11'd64, 64'h0000_0000_8000_0100, 16'd1, 1'b1, 32'd100);
      do_tlp(11'd64, 64'h0000_0000_8000_0100, 1'b1, 32'd100, 32'd0, 1'b0, 1'b1, 1'b0, "t4");
      chk_done("t4");

      // Endless burst ended by iSTOP raised mid-TLP
      start(11'd16, 64'h40, 16'd0, 1'b1, 32'h1000);
      do_tlp(11'd16, 64'h40, 1'b1, 32'h1000, 32'd0, 1'b0, 1'b0, 1'b0, "t5a");
      do_tlp(11'd16, 64'h80, 1'b1, 32'h1000, 32'd16, 1'b0, 1'b0, 1'b1, "t5b");
      chk_done("t5");
      iSTOP = 1'b0;

      // Rejected configurations
      bad_start(11'd12, 64'h0, "t6_n12");
      bad_start(11'd128, 64'h0000_0000_0000_0F00, "t6_align");
      bad_start(11'd2, 64'h0, "t6_n2");
      bad_start(11'd256, 64'h0, "t6_n256");

      // Asynchronous reset in the middle of a TLP
      start(11'd16, 64'h40, 16'd1, 1'b0, 32'h5555_5555);
      iGNT = 1'b1;
      tick();
      chk("t7_xfer_valid", 256'(oTX_ST.valid), 256'(1'b1));
      #2;
      iRST = 1'b1;
      #1;
      chk("t7_rst_st", 256'(oTX_ST), 256'(0));
      chk("t7_rst_req", 256'(oREQ), 256'(1'b0));
      chk("t7_rst_busy", 256'(oBUSY), 256'(1'b0));
      iGNT = 1'b0;
      tick();
      iRST = 1'b0;
      tick();
      chk("t7_after_req", 256'(oREQ), 256'(1'b0));
      chk("t7_after_data", oTX_DATA, 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
